// File: rtl/dtree_walk_ctrl.sv
// Sequential decision-tree walker: one node per cycle through a shared comparator.
// Optional macro DTREE_STEP_CNT_EN adds a registered visited-node count on out_steps.
module dtree_walk_ctrl #(
  parameter int unsigned NFEAT = 5,
  parameter int unsigned FW    = 8,
  parameter int unsigned CW    = 5,
  parameter int unsigned NW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NFEAT*FW-1:0]   in_feat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_class,
  output logic                  out_err,
  output logic [NW:0]           out_steps,
  input  logic                  cfg_we,
  input  logic [NW-1:0]         cfg_addr,
  input  logic [12+2*NW-1:0]    cfg_data,
  output logic                  cfg_ready
);

  localparam int unsigned NODES = 2 ** NW;
  localparam int unsigned EW    = 12 + 2 * NW;
  localparam int unsigned SW    = NW + 1;

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e                state_q, state_d;
  logic [NW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         step_q, step_d;
  logic [NFEAT*FW-1:0]   feat_q, feat_d;
  logic [CW-1:0]         class_q, class_d;
  logic                  err_q, err_d;
  logic [EW-1:0]         node_q [NODES];

  logic [EW-1:0]         entry;
  logic                  is_int;
  logic [2:0]            fsel;
  logic [FW-1:0]         thr;
  logic [NW-1:0]         left, right;
  logic [FW-1:0]         fval;
  logic [SW-1:0]         step_inc;

  assign entry    = node_q[idx_q];
  assign is_int   = entry[EW-1];
  assign fsel     = entry[EW-2 -: 3];
  assign thr      = entry[EW-5 -: FW];
  assign left     = entry[2*NW-1 -: NW];
  assign right    = entry[NW-1:0];
  assign step_inc = step_q + SW'(1);

  // Out-of-range feature selects read as zero.
  always_comb begin
    fval = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (fsel == 3'(i)) fval = feat_q[i*FW +: FW];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          feat_d  = in_feat;
          idx_d   = '0;
          step_d  = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        step_d = step_inc;
        if (!is_int) begin
          class_d = thr[CW-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (step_inc == SW'(NODES)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = (fval <= thr) ? left : right;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      step_q  <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Table is writable only while idle, so a walk never sees a partial update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
    end else if (cfg_we && cfg_ready) begin
      node_q[cfg_addr] <= cfg_data;
    end
  end

`ifdef DTREE_STEP_CNT_EN
  logic [SW-1:0] steps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else if (state_q == StWalk && state_d == StDone) begin
      steps_q <= step_inc;
    end
  end

  assign out_steps = steps_q;
`else
  assign out_steps = '0;
`endif

  assign in_ready  = (state_q == StIdle);
  assign cfg_ready = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_walk_ctrl.sv
// Randomized bench for dtree_walk_ctrl with a table-walking reference model and directed pins.
module tb_dtree_walk_ctrl;

`ifdef DTREE_STEP_CNT_EN
  localparam bit STEPS_ON = 1'b1;
`else
  localparam bit STEPS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_feat = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_class;
  logic        out_err;
  logic [4:0]  out_steps;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [19:0] cfg_data = '0;
  logic        cfg_ready;

  int npass = 0;
  int ntotal = 0;

  dtree_walk_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .out_steps (out_steps),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [19:0] node(input int in, input int f, input int thr,
                                       input int l, input int r);
    logic [31:0] a, b, c, d, e;
    a = in; b = f; c = thr; d = l; e = r;
    return {a[0], b[2:0], c[7:0], d[3:0], e[3:0]};
  endfunction

  // Reference table and walk, straight from the node-entry rules.
  logic [19:0] mdl [16];

  task automatic walk(input logic [39:0] f, output int cls, output int err, output int steps);
    int idx;
    logic [19:0] e;
    int fi, fv, th;
    idx = 0; cls = 0; err = 0; steps = 0;
    for (int s = 1; s <= 16; s++) begin
      e = mdl[idx];
      th = int'(e[15:8]);
      if (!e[19]) begin
        cls = th % 32; err = 0; steps = s;
        return;
      end
      if (s == 16) begin
        cls = 0; err = 1; steps = 16;
        return;
      end
      fi = int'(e[18:16]);
      fv = (fi < 5) ? int'((f >> (fi * 8)) & 40'hFF) : 0;
      idx = (fv <= th) ? int'(e[7:4]) : int'(e[3:0]);
    end
  endtask

  // Cycle-level model: 0 idle, 1 walking, 2 holding result.
  int m_st = 0, m_cnt = 0, e_cls = 0, e_err = 0, e_steps = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_st = 0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_out_class", int'(out_class), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_out_steps", int'(out_steps), 0);
    end else begin
      case (m_st)
        0: begin
          if (cfg_we) mdl[cfg_addr] = cfg_data;
          if (in_valid) begin
            walk(in_feat, e_cls, e_err, e_steps);
            m_cnt = 0;
            m_st = 1;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == e_steps) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
      chk("cyc_out_valid", int'(out_valid), int'(m_st == 2));
      chk("cyc_in_ready", int'(in_ready), int'(m_st == 0));
      chk("cyc_cfg_ready", int'(cfg_ready), int'(m_st == 0));
      if (m_st == 2) begin
        chk("cyc_out_class", int'(out_class), e_cls);
        chk("cyc_out_err", int'(out_err), e_err);
        chk("cyc_out_steps", int'(out_steps), STEPS_ON ? e_steps : 0);
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [19:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_sample(input logic [39:0] f, input int hold, input bit wc,
                            input logic [3:0] wa, input logic [19:0] wd,
                            output int cls, output int err, output int steps,
                            output int edges);
    @(negedge clk);
    in_valid = 1'b1; in_feat = f; out_ready = (hold == 0);
    cfg_we = wc; cfg_addr = wa; cfg_data = wd;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; in_feat = {$urandom, 8'($urandom)};
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) chk("timeout_out_valid", 0, 1);
    cls = int'(out_class); err = int'(out_err); steps = int'(out_steps);
    if (hold > 0) begin
      repeat (hold) begin
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = node(0, 0, 5, 0, 0);
        @(negedge clk);
      end
      cfg_we = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b1;
  endtask

  function automatic logic [19:0] rand_node();
    return node(($urandom % 5) != 0, $urandom % 8, $urandom % 256,
                $urandom % 16, $urandom % 16);
  endfunction

  initial begin
    int c, e, s, n;
    #1;
    chk("reset_in_ready_now", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_sample(40'h0, 0, 0, 0, 0, c, e, s, n);
    chk("empty_class", c, 0);
    chk("empty_err", e, 0);
    chk("empty_edge", n, 2);
    chk("empty_steps", s, STEPS_ON ? 1 : 0);

    cfg_write(4'd0, node(1, 0, 8'h3F, 1, 2));
    cfg_write(4'd1, node(0, 0, 24, 0, 0));
    cfg_write(4'd2, node(0, 0, 12, 0, 0));
    run_sample(40'h20, 0, 0, 0, 0, c, e, s, n);
    chk("tree_f20_class", c, 24);
    run_sample(40'h40, 0, 0, 0, 0, c, e, s, n);
    chk("tree_f40_class", c, 12);
    run_sample(40'h3F, 0, 0, 0, 0, c, e, s, n);
    chk("tree_f3f_class", c, 24);
    chk("tree_f3f_steps", s, STEPS_ON ? 2 : 0);
    chk("tree_f3f_edge", n, 3);

    run_sample(40'h20, 5, 0, 0, 0, c, e, s, n);
    chk("hold_class", c, 24);
    run_sample(40'h20, 0, 0, 0, 0, c, e, s, n);
    chk("hold_cfg_dropped", c, 24);

    cfg_write(4'd0, node(1, 7, 0, 1, 2));
    run_sample({5{8'hFF}}, 0, 0, 0, 0, c, e, s, n);
    chk("feat7_left", c, 24);

    run_sample(40'h0, 0, 1, 4'd0, node(0, 0, 7, 0, 0), c, e, s, n);
    chk("cfg_with_accept", c, 7);

    cfg_write(4'd0, node(1, 0, 0, 0, 0));
    run_sample(40'h10, 0, 0, 0, 0, c, e, s, n);
    chk("loop_err", e, 1);
    chk("loop_class", c, 0);
    chk("loop_edge", n, 17);
    chk("loop_steps", s, STEPS_ON ? 16 : 0);

    @(negedge clk);
    in_valid = 1'b1; in_feat = 40'h10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwalk_rst_in_ready", int'(in_ready), 1);
    chk("midwalk_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(40'h10, 0, 0, 0, 0, c, e, s, n);
    chk("cleared_err", e, 0);
    chk("cleared_edge", n, 2);

    for (int i = 0; i < 16; i++) cfg_write(4'(i), rand_node());
    repeat (3000) begin
      @(negedge clk);
      in_valid = ($urandom % 3) == 0;
      in_feat = {$urandom, 8'($urandom)};
      out_ready = $urandom % 2;
      cfg_we = ($urandom % 4) == 0;
      cfg_addr = $urandom % 16;
      cfg_data = rand_node();
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (25) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", npass, ntotal);
    $fatal(1);
  end

endmodule
